// File: rtl/vram_responder.sv
// Wishbone slave fronting a 2^ADDR_W x 32-bit VRAM window at BASE_ADDRESS.
// Optional one-word read prefetch buffer enabled by defining VRAM_PREFETCH_EN.
module vram_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h40100000,
  parameter int          ADDR_W       = 12
) (
  input  logic        clk_100MHz,
  input  logic        rst_n,
  input  logic [31:0] vr_dat_i,
  input  logic [31:0] vr_adr_i,
  input  logic        vr_cyc_i,
  input  logic        vr_stb_i,
  input  logic        vr_we_i,
  input  logic [3:0]  vr_sel_i,
  output logic [31:0] vr_dat_o,
  output logic        vr_ack_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;
  typedef enum logic [1:0] {SRC_HOLD, SRC_ZERO, SRC_MEM, SRC_PF} src_t;

  state_t             r_state;
  state_t             w_state_nxt;
  src_t               w_dat_src;

  logic [31:0]        r_mem [DEPTH];
  logic [31:0]        r_dat;
  logic               r_ack;
  logic [ADDR_W-1:0]  r_idx;
  logic               r_rd_hit;

  logic               w_hit;
  logic [ADDR_W-1:0]  w_idx;
  logic               w_wr_en;
  logic               w_cap_idx;
  logic               w_ack_nxt;
  logic               w_rd_hit_nxt;
  logic               w_pf_load;
  logic               w_pf_hit;
  logic [31:0]        w_pf_dat;
  logic               w_unused;

  assign w_hit    = (vr_adr_i[31:ADDR_W+2] == BASE_ADDRESS[31:ADDR_W+2]);
  assign w_idx    = vr_adr_i[ADDR_W+1:2];
  assign w_unused = &{1'b0, vr_adr_i[1:0]};

`ifdef VRAM_PREFETCH_EN
  logic [ADDR_W-1:0]  r_pf_tag;
  logic [31:0]        r_pf_dat;
  logic               r_pf_vld;
  logic [ADDR_W-1:0]  w_pf_idx;

  assign w_pf_idx = r_idx + 1'b1;
  assign w_pf_hit = r_pf_vld && (r_pf_tag == w_idx);
  assign w_pf_dat = r_pf_dat;

  // Prefetch happens on the ACK->IDLE edge, when the memory port is idle.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_pf_vld <= 1'b0;
    end else if (w_pf_load) begin
      r_pf_vld <= 1'b1;
    end else if (w_wr_en && (r_pf_tag == w_idx)) begin
      r_pf_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (w_pf_load) begin
      r_pf_tag <= w_pf_idx;
      r_pf_dat <= r_mem[w_pf_idx];
    end
  end
`else
  logic w_unused_pf;

  assign w_pf_hit    = 1'b0;
  assign w_pf_dat    = 32'h0;
  assign w_unused_pf = w_pf_load;
`endif

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_en      = 1'b0;
    w_cap_idx    = 1'b0;
    w_ack_nxt    = 1'b0;
    w_dat_src    = SRC_HOLD;
    w_rd_hit_nxt = r_rd_hit;
    w_pf_load    = 1'b0;
    case (r_state)
      IDLE: begin
        if (vr_cyc_i && vr_stb_i) begin
          w_cap_idx = 1'b1;
          if (vr_we_i) begin
            w_wr_en      = w_hit;
            w_ack_nxt    = 1'b1;
            w_rd_hit_nxt = 1'b0;
            w_state_nxt  = ACK;
          end else if (!w_hit) begin
            w_dat_src    = SRC_ZERO;
            w_ack_nxt    = 1'b1;
            w_rd_hit_nxt = 1'b0;
            w_state_nxt  = ACK;
          end else if (w_pf_hit) begin
            w_dat_src    = SRC_PF;
            w_ack_nxt    = 1'b1;
            w_rd_hit_nxt = 1'b1;
            w_state_nxt  = ACK;
          end else begin
            w_state_nxt  = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        // Master abandoned the cycle: return silently.
        if (!vr_cyc_i) begin
          w_rd_hit_nxt = 1'b0;
          w_state_nxt  = IDLE;
        end else begin
          w_dat_src    = SRC_MEM;
          w_ack_nxt    = 1'b1;
          w_rd_hit_nxt = 1'b1;
          w_state_nxt  = ACK;
        end
      end
      ACK: begin
        w_pf_load   = r_rd_hit;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_ack    <= 1'b0;
      r_dat    <= 32'h0;
      r_rd_hit <= 1'b0;
    end else begin
      r_ack    <= w_ack_nxt;
      r_rd_hit <= w_rd_hit_nxt;
      case (w_dat_src)
        SRC_ZERO: r_dat <= 32'h0;
        SRC_MEM:  r_dat <= r_mem[r_idx];
        SRC_PF:   r_dat <= w_pf_dat;
        default:  r_dat <= r_dat;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (w_cap_idx) begin
      r_idx <= w_idx;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (vr_sel_i[b]) begin
          r_mem[w_idx][8*b +: 8] <= vr_dat_i[8*b +: 8];
        end
      end
    end
  end

  assign vr_dat_o = r_dat;
  assign vr_ack_o = r_ack;

endmodule
